acm_in_arbiter: RTL and testbench
=================================

ACM_IN_ARBITER -- requirements
Module: acm_in_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of user input streams (legal 1..8).
REQ-002 SHALL have parameter MAX_BURST, default 64, max data beats per grant (legal 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 48000, idle clk_usb cycles before auto-flush (legal 2..2^20).
REQ-004 SHALL have parameter HDR_EN, default 1, 1 = insert channel header byte before each burst.
REQ-005 SHALL have port clk_usb  in  1  USB-domain clock; all logic on its rising edge.
REQ-006 SHALL have port rst_usb  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_data  in  8*N_CH  channel c byte at bits [8c+7:8c].
REQ-008 SHALL have ports s_valid, s_last  in  N_CH each  per-channel valid and end-of-message.
REQ-009 SHALL have port s_ready  out  N_CH  per-channel ready.
REQ-010 SHALL have ports m_data (out 8), m_last (out 1), m_valid (out 1), m_ready (in 1)  muacm IN pipe.
REQ-011 SHALL have port flush_now  out  1  single-cycle flush request to muacm.
REQ-012 SHALL have ports grant_ch (out 3, current channel) and busy (out 1, state != IDLE).

Function
REQ-013 SHALL implement FSM IDLE, HDR, DATA; m_data/m_last/m_valid registered (one output register stage).
REQ-014 IDLE: if any s_valid, grant first requesting channel searching round-robin from (last_grant+1) mod N_CH; go HDR if HDR_EN else DATA; else stay.
REQ-015 HDR: present m_data = 8'hC0 | grant_ch, m_last = 0, m_valid = 1; on m_ready go DATA; no s_ready asserted.
REQ-016 DATA: s_ready[grant_ch] = output register empty or m_ready; all other s_ready bits 0 at all times.
REQ-017 Each accepted source beat SHALL appear on m_data exactly once, in order, one cycle after acceptance; throughput one beat/cycle when m_ready held high.
REQ-018 Burst beat counter (width clog2(MAX_BURST+1)) SHALL clear on grant and increment per accepted beat.
REQ-019 Burst SHALL end (return to IDLE after last beat leaves output register) on: accepted s_last, or counter reaching MAX_BURST, or granted s_valid low for 1 cycle while any other channel s_valid high.
REQ-020 m_last SHALL be 1 on the final beat only when that beat carried s_last; MAX_BURST/preemption endings SHALL output m_last = 0.
REQ-021 flush_now SHALL pulse 1 cycle after a beat with m_last=1 is accepted by m_ready.
REQ-022 Idle counter SHALL clear on every m_valid&m_ready beat and increment otherwise while unflushed data exists; at TIMEOUT_CYC it SHALL pulse flush_now once and clear the unflushed flag.
REQ-023 Simultaneous explicit and timeout flush conditions SHALL yield a single flush_now pulse.
REQ-024 m_data/m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-025 With N_CH=1 arbitration SHALL always grant channel 0; grant_ch upper bits 0.

Reset
REQ-026 rst_usb assertion SHALL immediately force: FSM IDLE, m_valid 0, m_last 0, m_data 0, s_ready 0, flush_now 0, busy 0, counters 0, unflushed flag 0.
REQ-027 last_grant SHALL reset to N_CH-1 so channel 0 has first priority.
REQ-028 Reset mid-burst SHALL discard the output register contents; no partial beat emitted after release.
REQ-029 Outputs SHALL stay at reset values for the first cycle after rst_usb deasserts.

Verification
REQ-030 N_CH=2, HDR_EN=1, m_ready=1; ch0 sends 3 bytes 11,22,33 (last on 33) -> m stream C0,11,22,33, m_last only on 33, flush_now 1 cycle after 33.
REQ-031 Both channels continuously valid, MAX_BURST=4 -> grants alternate ch0,ch1,ch0; each burst 1 header + 4 data, m_last 0.
REQ-032 m_ready toggled 1-0 pseudo-randomly during ch1 burst -> no byte lost/duplicated, m_data stable while stalled.
REQ-033 TIMEOUT_CYC=100; ch0 sends 2 bytes without last, then idle -> exactly one flush_now 100 cycles after final m beat; none thereafter.
REQ-034 rst_usb asserted mid-burst with m_valid=1 -> m_valid 0 same cycle; after release ch0 granted first with fresh header.
REQ-035 HDR_EN=0, N_CH=1, 300-byte message, MAX_BURST=255 -> 255 then 45 bytes, no headers, m_last only on byte 300.

Source files
------------

// File: rtl/acm_in_arbiter.sv
// Round-robin merge of N_CH byte streams into the single muacm IN pipe, with
// optional channel header bytes, burst limiting and flush generation.
module acm_in_arbiter #(
    parameter int N_CH        = 2,
    parameter int MAX_BURST   = 64,
    parameter int TIMEOUT_CYC = 48000,
    parameter int HDR_EN      = 1
) (
    input  logic              clk_usb,
    input  logic              rst_usb,
    input  logic [8*N_CH-1:0] s_data,
    input  logic [N_CH-1:0]   s_valid,
    input  logic [N_CH-1:0]   s_last,
    output logic [N_CH-1:0]   s_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              flush_now,
    output logic [2:0]        grant_ch,
    output logic              busy
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    r_state;
    logic [2:0]    r_grant;
    logic [2:0]    r_last_grant;
    logic          r_armed;
    logic          r_end;
    logic [BW-1:0] r_cnt;
    logic [IW-1:0] r_idle;
    logic          r_unflushed;
    logic          r_flush;
    logic [7:0]    r_mdata;
    logic          r_mlast;
    logic          r_mvalid;

    logic          w_req;
    logic [2:0]    w_pick;
    logic [7:0]    w_sdata;
    logic          w_svalid;
    logic          w_slast;
    logic          w_others;
    logic          w_out_free;
    logic          w_open;
    logic          w_take;
    logic          w_m_fire;
    logic          w_preempt;
    logic [BW-1:0] w_cnt_inc;

    // Descending offsets so the channel nearest to last_grant+1 wins.
    always_comb begin
        w_req  = 1'b0;
        w_pick = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            for (int c = 0; c < N_CH; c++) begin
                if (s_valid[c] && (c == (int'(r_last_grant) + 1 + i) % N_CH)) begin
                    w_req  = 1'b1;
                    w_pick = 3'(c);
                end
            end
        end
    end

    always_comb begin
        w_sdata  = '0;
        w_svalid = 1'b0;
        w_slast  = 1'b0;
        w_others = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (3'(c) == r_grant) begin
                w_sdata  = s_data[8*c +: 8];
                w_svalid = s_valid[c];
                w_slast  = s_last[c];
            end else if (s_valid[c]) begin
                w_others = 1'b1;
            end
        end
    end

    assign w_out_free = !r_mvalid || m_ready;
    assign w_open     = (r_state == S_DATA) && !r_end;
    assign w_take     = w_open && w_out_free && w_svalid;
    assign w_m_fire   = r_mvalid && m_ready;
    assign w_preempt  = w_open && !w_svalid && w_others;
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_comb begin
        s_ready = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (3'(c) == r_grant) s_ready[c] = w_open && w_out_free;
        end
    end

    // r_armed holds the FSM in IDLE for the first cycle after reset release.
    always_ff @(posedge clk_usb or posedge rst_usb) begin
        if (rst_usb) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= 3'(N_CH - 1);
            r_armed      <= 1'b0;
            r_end        <= 1'b0;
            r_cnt        <= '0;
            r_mdata      <= '0;
            r_mlast      <= 1'b0;
            r_mvalid     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_m_fire) r_mvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_armed && w_req) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_cnt        <= '0;
                        r_end        <= 1'b0;
                        if (HDR_EN != 0) begin
                            r_state  <= S_HDR;
                            r_mvalid <= 1'b1;
                            r_mdata  <= 8'hC0 | {5'd0, w_pick};
                            r_mlast  <= 1'b0;
                        end else begin
                            r_state  <= S_DATA;
                        end
                    end
                end
                S_HDR: begin
                    if (m_ready) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_take) begin
                        r_mvalid <= 1'b1;
                        r_mdata  <= w_sdata;
                        r_mlast  <= w_slast;
                        r_cnt    <= w_cnt_inc;
                        if (w_slast || w_cnt_inc == BW'(MAX_BURST)) r_end <= 1'b1;
                    end else if (w_preempt) begin
                        r_end <= 1'b1;
                    end
                    // Leave only once the final beat has drained from the output register.
                    if (r_end && w_out_free) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Explicit and timeout flushes share one register, so coincident causes give one pulse.
    always_ff @(posedge clk_usb or posedge rst_usb) begin
        if (rst_usb) begin
            r_flush     <= 1'b0;
            r_unflushed <= 1'b0;
            r_idle      <= '0;
        end else begin
            r_flush <= 1'b0;
            if (w_m_fire) begin
                r_idle      <= '0;
                r_unflushed <= !r_mlast;
                r_flush     <= r_mlast;
            end else if (r_unflushed) begin
                if (r_idle == IW'(TIMEOUT_CYC - 2)) begin
                    r_flush     <= 1'b1;
                    r_unflushed <= 1'b0;
                    r_idle      <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end
        end
    end

    assign m_data    = r_mdata;
    assign m_last    = r_mlast;
    assign m_valid   = r_mvalid;
    assign flush_now = r_flush;
    assign grant_ch  = r_grant;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_acm_in_arbiter.sv
// Scoreboard bench: expected IN-pipe bytes are queued with the stimulus and
// popped as beats leave each DUT instance.
module tb_acm_in_arbiter;
    logic clk_usb = 1'b0;
    logic rst_usb = 1'b1;
    always #5 clk_usb = ~clk_usb;

    logic [15:0] s_data  = '0;
    logic [1:0]  s_valid = '0;
    logic [1:0]  s_last  = '0;
    logic [1:0]  s_ready;
    logic [7:0]  m_data;
    logic        m_last, m_valid, flush_now, busy;
    logic        m_ready = 1'b1;
    logic [2:0]  grant_ch;

    logic [7:0]  b_sdata  = '0;
    logic        b_svalid = 1'b0;
    logic        b_slast  = 1'b0;
    logic        b_sready;
    logic [7:0]  b_mdata;
    logic        b_mlast, b_mvalid, b_flush, b_busy;
    logic [2:0]  b_grant;

    acm_in_arbiter #(.N_CH(2), .MAX_BURST(4), .TIMEOUT_CYC(100), .HDR_EN(1)) u_dut (
        .clk_usb(clk_usb), .rst_usb(rst_usb),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .flush_now(flush_now), .grant_ch(grant_ch), .busy(busy)
    );

    acm_in_arbiter #(.N_CH(1), .MAX_BURST(255), .TIMEOUT_CYC(1000), .HDR_EN(0)) u_dut_b (
        .clk_usb(clk_usb), .rst_usb(rst_usb),
        .s_data(b_sdata), .s_valid(b_svalid), .s_last(b_slast), .s_ready(b_sready),
        .m_data(b_mdata), .m_last(b_mlast), .m_valid(b_mvalid), .m_ready(1'b1),
        .flush_now(b_flush), .grant_ch(b_grant), .busy(b_busy)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    int flushes, flush_cyc, beat_cyc, b_rises, rdy_mode;
    logic [8:0] q0[$], q1[$], b_q[$];
    logic [9:0] exp_q[$], b_exp[$];
    logic       prev_stall = 1'b0, b_busy_q = 1'b0;
    logic [8:0] prev_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive on the falling edge, sample handshakes 1 ns later, before the rising edge.
    task automatic step();
        logic [9:0] e;
        @(negedge clk_usb);
        cyc++;
        m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_valid = '0; s_last = '0; s_data = '0;
        if (q0.size() > 0) begin s_valid[0] = 1'b1; s_data[7:0]  = q0[0][7:0]; s_last[0] = q0[0][8]; end
        if (q1.size() > 0) begin s_valid[1] = 1'b1; s_data[15:8] = q1[0][7:0]; s_last[1] = q1[0][8]; end
        b_svalid = 1'b0; b_sdata = '0; b_slast = 1'b0;
        if (b_q.size() > 0) begin b_svalid = 1'b1; b_sdata = b_q[0][7:0]; b_slast = b_q[0][8]; end
        #1;
        if (rst_usb) begin
            prev_stall = 1'b0;
            b_busy_q   = 1'b0;
        end else begin
            if (flush_now) begin flushes++; flush_cyc = cyc; end
            if (prev_stall) chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, prev_out});
            if (s_valid[0] && s_ready[0]) void'(q0.pop_front());
            if (s_valid[1] && s_ready[1]) void'(q1.pop_front());
            if (m_valid && m_ready) begin
                beat_cyc = cyc;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                chk("m_beat", {m_last, m_data}, e);
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_last, m_data};
            if (b_svalid && b_sready) void'(b_q.pop_front());
            if (b_mvalid) begin
                e = (b_exp.size() > 0) ? b_exp.pop_front() : 10'h3FF;
                chk("b_beat", {b_mlast, b_mdata}, e);
            end
            if (b_busy && !b_busy_q) b_rises++;
            b_busy_q = b_busy;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_usb = 1'b1;
        step();
        step();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", {m_last, m_data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_flush", flush_now, 0);
        rst_usb = 1'b0;
        step();
        chk("post_rst_hold", {busy, m_valid, s_ready}, 0);
        flushes = 0;
        b_rises = 0;
    endtask

    task automatic pe(input logic [8:0] v);
        exp_q.push_back({1'b0, v});
    endtask

    initial begin
        rdy_mode = 0;

        // Short message on ch0 with header and explicit flush.
        q0 = '{9'h011, 9'h022, 9'h133};
        pe(9'h0C0); pe(9'h011); pe(9'h022); pe(9'h133);
        do_reset();
        run(20);
        chk("t30_left", exp_q.size(), 0);
        chk("t30_flushes", flushes, 1);
        chk("t30_flush_dly", flush_cyc - beat_cyc, 1);

        // Both channels streaming, bursts of 4 alternate starting with ch0.
        for (int k = 0; k < 12; k++) begin
            q0.push_back(9'(8'h01 + k));
            q1.push_back(9'(8'h81 + k));
        end
        for (int b = 0; b < 3; b++) begin
            pe(9'h0C0);
            for (int k = 0; k < 4; k++) pe(9'(8'h01 + 4 * b + k));
            pe(9'h0C1);
            for (int k = 0; k < 4; k++) pe(9'(8'h81 + 4 * b + k));
        end
        do_reset();
        run(60);
        chk("t31_left", exp_q.size(), 0);
        chk("t31_no_flush", flushes, 0);

        // Random backpressure during a ch1 message split across two bursts.
        q1 = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h0A5, 9'h1A6};
        pe(9'h0C1); pe(9'h0A1); pe(9'h0A2); pe(9'h0A3); pe(9'h0A4);
        pe(9'h0C1); pe(9'h0A5); pe(9'h1A6);
        do_reset();
        rdy_mode = 1;
        run(80);
        rdy_mode = 0;
        run(5);
        chk("t32_left", exp_q.size(), 0);
        chk("t32_flushes", flushes, 1);

        // ch0 runs dry while ch1 waits: ch0 burst ends without m_last.
        q0 = '{9'h031, 9'h032};
        q1 = '{9'h141};
        pe(9'h0C0); pe(9'h031); pe(9'h032); pe(9'h0C1); pe(9'h141);
        do_reset();
        run(30);
        chk("pre_left", exp_q.size(), 0);

        // Unterminated data flushes once on timeout.
        q0 = '{9'h055, 9'h066};
        pe(9'h0C0); pe(9'h055); pe(9'h066);
        do_reset();
        run(250);
        chk("t33_left", exp_q.size(), 0);
        chk("t33_flushes", flushes, 1);
        chk("t33_flush_dly", flush_cyc - beat_cyc, 100);

        // Async reset while a header is stalled; it must be discarded.
        q1 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
        pe(9'h0C1);
        rdy_mode = 2;
        do_reset();
        run(4);
        chk("t34_stall_hdr", {m_valid, m_data}, {1'b1, 8'hC1});
        @(negedge clk_usb);
        #2 rst_usb = 1'b1;
        #1;
        chk("t34_async_mvalid", m_valid, 0);
        chk("t34_async_busy", busy, 0);
        q0.delete(); q1.delete(); exp_q.delete();
        q0 = '{9'h15A};
        q1 = '{9'h16B};
        pe(9'h0C0); pe(9'h15A); pe(9'h0C1); pe(9'h16B);
        rdy_mode = 0;
        do_reset();
        run(30);
        chk("t34_left", exp_q.size(), 0);
        chk("t34_flushes", flushes, 2);

        // Single channel, no headers: 300 bytes split 255 + 45.
        for (int i = 0; i < 300; i++) begin
            logic [9:0] v;
            v = {1'b0, (i == 299), 8'(i)};
            b_q.push_back(v[8:0]);
            b_exp.push_back(v);
        end
        do_reset();
        run(340);
        chk("t35_left", b_exp.size(), 0);
        chk("t35_bursts", b_rises, 2);
        chk("t35_grant", b_grant, 0);
        chk("t35_a_quiet", exp_q.size() + q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
